fb_mem_arbiter: RTL and testbench

- Owns the single-port 640x480x8 grayscale pixel RAM and sequences every access to it.
- Serves two masters:
  - VGA scan-out reads, driven by the vga_controller coordinates. These always have priority.
  - A pixel-writer stream. Writes are queued in a small FIFO and committed only in blanking slots.
- Sits between vga_controller, the pixel source (loader/drawing engine) and mem.

---
 rtl/fb_mem_arbiter.sv | 88 ++++++++
 tb/tb_fb_mem_arbiter.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/fb_mem_arbiter.sv
// fb_mem_arbiter: single-port framebuffer RAM sequencer, scan-out reads first, queued writes in blanking slots
module fb_mem_arbiter #(
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480,
  parameter int ADDR_W   = 19,
  parameter int DATA_W   = 8,
  parameter int WQ_DEPTH = 4
) (
  input  logic                           clk_25,
  input  logic                           n_rst,
  input  logic [9:0]                     x_coordinate,
  input  logic [9:0]                     y_coordinate,
  input  logic                           vblank_only,
  input  logic                           wr_valid,
  output logic                           wr_ready,
  input  logic [ADDR_W-1:0]              wr_addr,
  input  logic [DATA_W-1:0]              wr_data,
  output logic [ADDR_W-1:0]              mem_address,
  output logic [DATA_W-1:0]              mem_data,
  output logic                           mem_wren,
  input  logic [DATA_W-1:0]              mem_q,
  output logic [DATA_W-1:0]              pixel_out,
  output logic                           pixel_valid,
  output logic [$clog2(WQ_DEPTH+1)-1:0]  wq_count,
  output logic                           addr_err
);
  localparam int PTR_W = $clog2(WQ_DEPTH);
  localparam int CNT_W = $clog2(WQ_DEPTH + 1);
  localparam logic [9:0]        H_LIM = 10'(H_ACTIVE);
  localparam logic [9:0]        V_LIM = 10'(V_ACTIVE);
  localparam logic [ADDR_W-1:0] PIX_N = ADDR_W'(H_ACTIVE * V_ACTIVE);
  localparam logic [CNT_W-1:0]  CNT_FULL = CNT_W'(WQ_DEPTH);
  typedef enum logic [1:0] {ST_SCAN, ST_HBLANK, ST_VBLANK} state_t;
  state_t             state_q, state_d;
  logic               rd_need, in_lines, push, addr_ok, enq, pop, wr_slot;
  logic [ADDR_W-1:0]  scan_addr;
  logic [ADDR_W-1:0]  wq_addr_q [WQ_DEPTH];
  logic [DATA_W-1:0]  wq_data_q [WQ_DEPTH];
  logic [PTR_W-1:0]   wp_q, rp_q;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  assign in_lines  = y_coordinate < V_LIM;
  assign rd_need   = (x_coordinate < H_LIM) && in_lines;
  assign state_d   = rd_need ? ST_SCAN : (in_lines ? ST_HBLANK : ST_VBLANK);
  assign scan_addr = ADDR_W'(y_coordinate) * ADDR_W'(H_ACTIVE) + ADDR_W'(x_coordinate);
  assign wr_ready  = cnt_q < CNT_FULL;
  assign push      = wr_valid && wr_ready;
  assign addr_ok   = wr_addr < PIX_N;
  assign enq       = push && addr_ok;
  // Horizontal blanking is only a write slot when tearing is tolerated
  assign wr_slot   = (state_d == ST_VBLANK) || ((state_d == ST_HBLANK) && !vblank_only);
  assign pop       = wr_slot && (cnt_q != '0);
  assign cnt_d     = cnt_q + CNT_W'(enq) - CNT_W'(pop);
  assign wq_count  = cnt_q;
  assign pixel_out = pixel_valid ? mem_q : '0;
  always_ff @(posedge clk_25) begin
    if (enq) begin
      wq_addr_q[wp_q] <= wr_addr;
      wq_data_q[wp_q] <= wr_data;
    end
  end
  // state_q is rd_need one cycle late, so pixel_valid lands with mem_q two cycles after the coordinates
  always_ff @(posedge clk_25 or negedge n_rst) begin
    if (!n_rst) begin
      state_q     <= ST_VBLANK;
      mem_address <= '0;
      mem_data    <= '0;
      mem_wren    <= 1'b0;
      pixel_valid <= 1'b0;
      wp_q        <= '0;
      rp_q        <= '0;
      cnt_q       <= '0;
      addr_err    <= 1'b0;
    end else begin
      state_q     <= state_d;
      mem_wren    <= pop;
      pixel_valid <= state_q == ST_SCAN;
      cnt_q       <= cnt_d;
      if (state_d == ST_SCAN) mem_address <= scan_addr;
      else if (pop) begin
        mem_address <= wq_addr_q[rp_q];
        mem_data    <= wq_data_q[rp_q];
      end
      if (enq) wp_q <= wp_q + PTR_W'(1);
      if (pop) rp_q <= rp_q + PTR_W'(1);
      if (push && !addr_ok) addr_err <= 1'b1;
    end
  end
endmodule

// File: tb/tb_fb_mem_arbiter.sv
// tb_fb_mem_arbiter: directed checks of scan-out, queued blanking writes, address errors and reset flush
module tb_fb_mem_arbiter;
  logic        clk_25 = 1'b0;
  logic        n_rst = 1'b0;
  logic [9:0]  x_coordinate = '0, y_coordinate = '0;
  logic        vblank_only = 1'b0, wr_valid = 1'b0, wr_ready;
  logic [18:0] wr_addr = '0, mem_address;
  logic [7:0]  wr_data = '0, mem_data, mem_q = '0, pixel_out;
  logic        mem_wren, pixel_valid, addr_err;
  logic [2:0]  wq_count;
  logic        pre_we = 1'b0;
  logic [18:0] pre_addr = '0;
  logic [7:0]  pre_data = '0;
  logic [7:0]  ram [0:(1<<19)-1];
  int checks = 0, failures = 0;

  fb_mem_arbiter dut (
    .clk_25(clk_25), .n_rst(n_rst), .x_coordinate(x_coordinate), .y_coordinate(y_coordinate),
    .vblank_only(vblank_only), .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr),
    .wr_data(wr_data), .mem_address(mem_address), .mem_data(mem_data), .mem_wren(mem_wren),
    .mem_q(mem_q), .pixel_out(pixel_out), .pixel_valid(pixel_valid), .wq_count(wq_count),
    .addr_err(addr_err)
  );

  always #20 clk_25 = ~clk_25;

  // Synchronous single-port RAM: read data one cycle after the address, old data on collision
  always @(posedge clk_25) begin
    if (mem_wren) ram[mem_address] <= mem_data;
    else if (pre_we) ram[pre_addr] <= pre_data;
    mem_q <= ram[mem_address];
  end

  task automatic tick();
    @(posedge clk_25);
    #1;
  endtask

  task automatic set_xy(input int x, input int y);
    x_coordinate = 10'(x);
    y_coordinate = 10'(y);
  endtask

  task automatic preload(input int a, input logic [7:0] d);
    pre_we = 1'b1; pre_addr = 19'(a); pre_data = d;
    tick();
    pre_we = 1'b0;
  endtask

  task automatic test_reset();
    n_rst = 1'b0;
    set_xy(700, 500);
    preload(0, 8'h11);
    preload(307199, 8'hA5);
    preload(401, 8'h00);
    tick();
    checks++; if (mem_address !== 19'd0) begin failures++; $display("FAIL rst_addr got=%0d exp=0", mem_address); end
    checks++; if (mem_wren !== 1'b0) begin failures++; $display("FAIL rst_wren got=%b exp=0", mem_wren); end
    checks++; if (mem_data !== 8'h00) begin failures++; $display("FAIL rst_data got=%h exp=00", mem_data); end
    checks++; if (pixel_valid !== 1'b0 || pixel_out !== 8'h00) begin failures++; $display("FAIL rst_pixel got=%b/%h exp=0/00", pixel_valid, pixel_out); end
    checks++; if (wq_count !== 3'd0 || wr_ready !== 1'b1) begin failures++; $display("FAIL rst_queue got=%0d/%b exp=0/1", wq_count, wr_ready); end
    checks++; if (addr_err !== 1'b0) begin failures++; $display("FAIL rst_err got=%b exp=0", addr_err); end
    n_rst = 1'b1;
  endtask

  task automatic test_scan_start();
    set_xy(0, 0);
    tick();
    checks++; if (mem_address !== 19'd0) begin failures++; $display("FAIL scan0_addr got=%0d exp=0", mem_address); end
    checks++; if (pixel_valid !== 1'b0) begin failures++; $display("FAIL scan0_valid_early got=%b exp=0", pixel_valid); end
    set_xy(1, 0);
    tick();
    checks++; if (mem_address !== 19'd1 || mem_wren !== 1'b0) begin failures++; $display("FAIL scan1_addr got=%0d/%b exp=1/0", mem_address, mem_wren); end
    checks++; if (pixel_valid !== 1'b1 || pixel_out !== 8'h11) begin failures++; $display("FAIL scan0_pixel got=%b/%h exp=1/11", pixel_valid, pixel_out); end
  endtask

  task automatic test_last_pixel();
    set_xy(639, 479);
    tick();
    checks++; if (mem_address !== 19'd307199) begin failures++; $display("FAIL last_addr got=%0d exp=307199", mem_address); end
    set_xy(640, 479);
    tick();
    checks++; if (pixel_valid !== 1'b1 || pixel_out !== 8'hA5) begin failures++; $display("FAIL last_pixel got=%b/%h exp=1/a5", pixel_valid, pixel_out); end
    set_xy(641, 479);
    tick();
    checks++; if (pixel_valid !== 1'b0 || pixel_out !== 8'h00) begin failures++; $display("FAIL blank_black got=%b/%h exp=0/00", pixel_valid, pixel_out); end
    checks++; if (mem_address !== 19'd307199) begin failures++; $display("FAIL blank_hold_addr got=%0d exp=307199", mem_address); end
  endtask

  task automatic test_hblank_write();
    int bad = 0;
    vblank_only = 1'b0;
    set_xy(10, 5);
    wr_valid = 1'b1; wr_addr = 19'd100; wr_data = 8'h3C;
    tick();
    wr_valid = 1'b0;
    checks++; if (wq_count !== 3'd1) begin failures++; $display("FAIL hb_count got=%0d exp=1", wq_count); end
    for (int x = 11; x < 640; x++) begin
      set_xy(x, 5);
      tick();
      if (mem_wren !== 1'b0) bad++;
    end
    checks++; if (bad != 0 || mem_wren !== 1'b0) begin failures++; $display("FAIL hb_no_wren_scan got=%0d exp=0", bad); end
    set_xy(640, 5);
    tick();
    checks++; if (mem_wren !== 1'b1 || mem_address !== 19'd100 || mem_data !== 8'h3C) begin failures++; $display("FAIL hb_write got=%b/%0d/%h exp=1/100/3c", mem_wren, mem_address, mem_data); end
    checks++; if (wq_count !== 3'd0) begin failures++; $display("FAIL hb_drain got=%0d exp=0", wq_count); end
    set_xy(641, 5);
    tick();
    checks++; if (mem_wren !== 1'b0) begin failures++; $display("FAIL hb_single got=%b exp=0", mem_wren); end
    set_xy(100, 0);
    tick();
    set_xy(101, 0);
    tick();
    checks++; if (pixel_valid !== 1'b1 || pixel_out !== 8'h3C) begin failures++; $display("FAIL hb_readback got=%b/%h exp=1/3c", pixel_valid, pixel_out); end
  endtask

  task automatic test_vblank_only();
    vblank_only = 1'b1;
    set_xy(20, 10);
    for (int i = 0; i < 4; i++) begin
      wr_valid = 1'b1; wr_addr = 19'(200 + i); wr_data = 8'(8'h50 + i);
      tick();
    end
    checks++; if (wq_count !== 3'd4 || wr_ready !== 1'b0) begin failures++; $display("FAIL vb_full got=%0d/%b exp=4/0", wq_count, wr_ready); end
    wr_addr = 19'd204; wr_data = 8'h54;
    tick();
    checks++; if (wq_count !== 3'd4 || wr_ready !== 1'b0) begin failures++; $display("FAIL vb_hold got=%0d/%b exp=4/0", wq_count, wr_ready); end
    set_xy(700, 10);
    tick();
    tick();
    checks++; if (mem_wren !== 1'b0 || wq_count !== 3'd4) begin failures++; $display("FAIL vb_no_hblank got=%b/%0d exp=0/4", mem_wren, wq_count); end
    set_xy(0, 480);
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++; if (mem_wren !== 1'b1 || mem_address !== 19'(200 + i) || mem_data !== 8'(8'h50 + i)) begin failures++; $display("FAIL vb_pop%0d got=%b/%0d/%h exp=1/%0d/%h", i, mem_wren, mem_address, mem_data, 200 + i, 8'h50 + i); end
      if (i == 0) begin
        checks++; if (wr_ready !== 1'b1 || wq_count !== 3'd3) begin failures++; $display("FAIL vb_ready_back got=%b/%0d exp=1/3", wr_ready, wq_count); end
      end
      if (i == 1) begin
        wr_valid = 1'b0;
        checks++; if (wq_count !== 3'd3) begin failures++; $display("FAIL vb_push_pop got=%0d exp=3", wq_count); end
      end
    end
    tick();
    checks++; if (mem_wren !== 1'b0 || wq_count !== 3'd0) begin failures++; $display("FAIL vb_empty got=%b/%0d exp=0/0", mem_wren, wq_count); end
  endtask

  task automatic test_addr_err();
    vblank_only = 1'b0;
    set_xy(5, 5);
    wr_valid = 1'b1; wr_addr = 19'd307200; wr_data = 8'h77;
    #1;
    checks++; if (wr_ready !== 1'b1) begin failures++; $display("FAIL err_handshake got=%b exp=1", wr_ready); end
    tick();
    wr_addr = 19'd300; wr_data = 8'h99;
    checks++; if (wq_count !== 3'd0 || addr_err !== 1'b1) begin failures++; $display("FAIL err_drop got=%0d/%b exp=0/1", wq_count, addr_err); end
    tick();
    wr_valid = 1'b0;
    checks++; if (wq_count !== 3'd1 || addr_err !== 1'b1) begin failures++; $display("FAIL err_next_push got=%0d/%b exp=1/1", wq_count, addr_err); end
    set_xy(640, 5);
    tick();
    checks++; if (mem_wren !== 1'b1 || mem_address !== 19'd300 || mem_data !== 8'h99) begin failures++; $display("FAIL err_write got=%b/%0d/%h exp=1/300/99", mem_wren, mem_address, mem_data); end
    set_xy(641, 5);
    tick();
    checks++; if (addr_err !== 1'b1 || ram[300] !== 8'h99) begin failures++; $display("FAIL err_sticky got=%b/%h exp=1/99", addr_err, ram[300]); end
  endtask

  task automatic test_reset_flush();
    int bad = 0;
    vblank_only = 1'b1;
    set_xy(0, 0);
    for (int i = 0; i < 4; i++) begin
      wr_valid = 1'b1; wr_addr = 19'(400 + i); wr_data = 8'(8'hE0 + i);
      tick();
    end
    wr_valid = 1'b0;
    set_xy(0, 500);
    tick();
    checks++; if (mem_wren !== 1'b1 || wq_count !== 3'd3) begin failures++; $display("FAIL rf_pre got=%b/%0d exp=1/3", mem_wren, wq_count); end
    #5 n_rst = 1'b0;
    #1;
    checks++; if (mem_wren !== 1'b0 || wq_count !== 3'd0) begin failures++; $display("FAIL rf_async got=%b/%0d exp=0/0", mem_wren, wq_count); end
    checks++; if (addr_err !== 1'b0) begin failures++; $display("FAIL rf_err_clr got=%b exp=0", addr_err); end
    tick();
    n_rst = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (mem_wren !== 1'b0) bad++;
    end
    checks++; if (bad != 0 || ram[401] !== 8'h00) begin failures++; $display("FAIL rf_no_stale got=%0d/%h exp=0/00", bad, ram[401]); end
    set_xy(1, 0);
    tick();
    checks++; if (mem_address !== 19'd1 || mem_wren !== 1'b0) begin failures++; $display("FAIL rf_resume got=%0d/%b exp=1/0", mem_address, mem_wren); end
  endtask

  initial begin
    test_reset();
    test_scan_start();
    test_last_pixel();
    test_hblank_write();
    test_vblank_only();
    test_addr_err();
    test_reset_flush();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
